unidade_controle_jogo_param: RTL

//  Parametrised Moore control unit for the memory-sequence game, successor of the exp6 control unit.
//  It owns the address, round and state-timer counters, which the previous generation took from the datapath.

---
 rtl/jogo_pkg.sv | 46 ++++
 rtl/unidade_controle_jogo_param_temporizador.sv | 40 ++++
 rtl/unidade_controle_jogo_param.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/jogo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : jogo_pkg
// Brief   : State codes, display constants and sizing helpers for the
//           memory-sequence game control unit.
// Rev     : 1.0
// ============================================================================
package jogo_pkg;

  // The enum values are the display codes themselves, so db_estado is the state.
  typedef enum logic [4:0] {
    S_INICIAL        = 5'h00,
    S_PREPARACAO     = 5'h01,
    S_INICIA_RODADA  = 5'h02,
    S_ESPERA_JOGADA  = 5'h03,
    S_REGISTRA       = 5'h04,
    S_COMPARACAO     = 5'h05,
    S_PROXIMO        = 5'h06,
    S_ULTIMA_RODADA  = 5'h07,
    S_PROXIMA_RODADA = 5'h08,
    S_MOSTRA_ACENDE  = 5'h09,
    S_FIM_ACERTOU    = 5'h0A,
    S_MOSTRA_APAGA   = 5'h0B,
    S_FIM_TIMEOUT    = 5'h0C,
    S_PROXIMO_MOSTRA = 5'h0D,
    S_FIM_ERROU      = 5'h0E,
    S_INICIA_JOGADA  = 5'h0F
  } estado_t;

  localparam logic [4:0] DB_INVALIDO = 5'h1F;

  function automatic int clog2(input int valor);
    int r;
    r = 0;
    while ((1 << r) < valor) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/unidade_controle_jogo_param_temporizador.sv
`default_nettype none
// ============================================================================
// Module  : temporizador_estado
// Brief   : Saturating up-counter with synchronous clear, used as state timer.
// Rev     : 1.0
// ============================================================================
module temporizador_estado #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         limpa,
  input  logic         conta,
  output logic [W-1:0] valor
);

  logic [W-1:0] valor_q;
  logic [W-1:0] valor_d;

  always_comb begin
    valor_d = valor_q;
    if (limpa) begin
      valor_d = '0;
    end else if (conta && (valor_q != {W{1'b1}})) begin
      valor_d = valor_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valor_q <= '0;
    end else begin
      valor_q <= valor_d;
    end
  end

  assign valor = valor_q;

endmodule
`default_nettype wire

// File: rtl/unidade_controle_jogo_param.sv
`default_nettype none
// ============================================================================
// Module  : unidade_controle_jogo_param
// Brief   : Moore control unit for the memory-sequence game: shows the stored
//           sequence, collects moves, owns address/round/timer counters.
// Rev     : 1.0
// ============================================================================
module unidade_controle_jogo_param
  import jogo_pkg::*;
#(
  parameter int N_JOGADAS = 16,
  parameter int ADDR_W    = 4,
  parameter int T_TIMEOUT = 5000,
  parameter int T_LED_ON  = 1000,
  parameter int T_LED_OFF = 500
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              jogada,
  input  logic              igual,
  input  logic              nivel,
  input  logic              modo_timeout_en,
  output logic [ADDR_W-1:0] endereco,
  output logic [ADDR_W-1:0] rodada,
  output logic              zeraR,
  output logic              registraR,
  output logic              mostra_led,
  output logic              jogada_ativa,
  output logic              acertou,
  output logic              errou,
  output logic              timeout,
  output logic              pronto,
  output logic [4:0]        db_estado
);

  localparam int TW = clog2(max3(T_TIMEOUT, T_LED_ON, T_LED_OFF));

  localparam logic [TW-1:0]     C_FIM_LED_ON  = TW'(T_LED_ON - 1);
  localparam logic [TW-1:0]     C_FIM_LED_OFF = TW'(T_LED_OFF - 1);
  localparam logic [TW-1:0]     C_FIM_TIMEOUT = TW'(T_TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] C_ULT_RODADA_MAX = ADDR_W'(N_JOGADAS - 1);
  localparam logic [ADDR_W-1:0] C_ULT_RODADA_MIN = ADDR_W'(N_JOGADAS / 2 - 1);

  estado_t           estado_q, estado_d;
  logic [ADDR_W-1:0] endereco_q, endereco_d;
  logic [ADDR_W-1:0] rodada_q, rodada_d;
  logic              nivel_q, nivel_d;
  logic              modo_q, modo_d;
  logic [TW-1:0]     w_timer;
  logic              w_fim_t;
  logic [ADDR_W-1:0] w_ult_rodada;

  // Timer restarts on every state change so each state measures its own dwell.
  temporizador_estado #(.W(TW)) u_temporizador (
    .clock (clock),
    .reset (reset),
    .limpa (estado_d != estado_q),
    .conta (1'b1),
    .valor (w_timer)
  );

  assign w_fim_t      = modo_q && (w_timer == C_FIM_TIMEOUT);
  assign w_ult_rodada = nivel_q ? C_ULT_RODADA_MAX : C_ULT_RODADA_MIN;

  always_comb begin
    estado_d     = estado_q;
    endereco_d   = endereco_q;
    rodada_d     = rodada_q;
    nivel_d      = nivel_q;
    modo_d       = modo_q;
    zeraR        = 1'b0;
    registraR    = 1'b0;
    mostra_led   = 1'b0;
    jogada_ativa = 1'b0;
    acertou      = 1'b0;
    errou        = 1'b0;
    timeout      = 1'b0;
    pronto       = 1'b0;
    db_estado    = estado_q;
    case (estado_q)
      S_INICIAL: begin
        zeraR = 1'b1;
        if (iniciar) estado_d = S_PREPARACAO;
      end
      S_PREPARACAO: begin
        zeraR      = 1'b1;
        rodada_d   = '0;
        endereco_d = '0;
        nivel_d    = nivel;
        modo_d     = modo_timeout_en;
        estado_d   = S_INICIA_RODADA;
      end
      S_INICIA_RODADA: begin
        endereco_d = '0;
        estado_d   = S_MOSTRA_ACENDE;
      end
      S_MOSTRA_ACENDE: begin
        mostra_led = 1'b1;
        if (w_timer == C_FIM_LED_ON) estado_d = S_MOSTRA_APAGA;
      end
      S_MOSTRA_APAGA: begin
        if (w_timer == C_FIM_LED_OFF) begin
          estado_d = (endereco_q == rodada_q) ? S_INICIA_JOGADA : S_PROXIMO_MOSTRA;
        end
      end
      S_PROXIMO_MOSTRA: begin
        endereco_d = endereco_q + 1'b1;
        estado_d   = S_MOSTRA_ACENDE;
      end
      S_INICIA_JOGADA: begin
        endereco_d = '0;
        estado_d   = S_ESPERA_JOGADA;
      end
      S_ESPERA_JOGADA: begin
        jogada_ativa = 1'b1;
        if (jogada)       estado_d = S_REGISTRA;
        else if (w_fim_t) estado_d = S_FIM_TIMEOUT;
      end
      S_REGISTRA: begin
        registraR = 1'b1;
        estado_d  = S_COMPARACAO;
      end
      S_COMPARACAO: begin
        if (!igual)                       estado_d = S_FIM_ERROU;
        else if (endereco_q == rodada_q)  estado_d = S_ULTIMA_RODADA;
        else                              estado_d = S_PROXIMO;
      end
      S_PROXIMO: begin
        endereco_d = endereco_q + 1'b1;
        estado_d   = S_ESPERA_JOGADA;
      end
      S_ULTIMA_RODADA: begin
        estado_d = (rodada_q == w_ult_rodada) ? S_FIM_ACERTOU : S_PROXIMA_RODADA;
      end
      S_PROXIMA_RODADA: begin
        rodada_d = rodada_q + 1'b1;
        estado_d = S_INICIA_RODADA;
      end
      S_FIM_ACERTOU: begin
        acertou = 1'b1;
        pronto  = 1'b1;
        if (iniciar) estado_d = S_PREPARACAO;
      end
      S_FIM_ERROU: begin
        errou  = 1'b1;
        pronto = 1'b1;
        if (iniciar) estado_d = S_PREPARACAO;
      end
      S_FIM_TIMEOUT: begin
        timeout = 1'b1;
        pronto  = 1'b1;
        if (iniciar) estado_d = S_PREPARACAO;
      end
      default: begin
        db_estado = DB_INVALIDO;
        estado_d  = S_INICIAL;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= S_INICIAL;
      endereco_q <= '0;
      rodada_q   <= '0;
      nivel_q    <= 1'b0;
      modo_q     <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      endereco_q <= endereco_d;
      rodada_q   <= rodada_d;
      nivel_q    <= nivel_d;
      modo_q     <= modo_d;
    end
  end

  assign endereco = endereco_q;
  assign rodada   = rodada_q;

endmodule
`default_nettype wire
